// File: rtl/dds_phase_gen_if.sv
// rtl/dds_phase_gen_if.sv - phase-word stream channel between the generator and the DDS core
interface dds_phase_gen_if #(
    parameter int PHASE_W = 8
);
    logic [PHASE_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - gated DDS phase-word generator: FTW accumulator plus phase offset, fixed beat count
module dds_phase_gen #(
    parameter int PHASE_W = 8,
    parameter int LEN_W   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [PHASE_W-1:0]   cfg_ftw,
    input  logic [PHASE_W-1:0]   cfg_poff,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    dds_phase_gen_if.master      m_axis_phase
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw;
    logic [PHASE_W-1:0] r_poff;
    logic [LEN_W-1:0]   r_count;
    logic [PHASE_W-1:0] r_tdata;
    logic               r_tvalid;
    logic               r_busy;
    logic               r_done;

    logic               w_hs;
    logic [PHASE_W-1:0] w_acc_next;
    logic               w_last;

    // Transfer qualifier and next accumulator value; sums wrap silently mod 2^PHASE_W.
    assign w_hs       = r_tvalid & m_axis_phase.tready;
    assign w_acc_next = r_acc + r_ftw;
    assign w_last     = (r_count == LEN_W'(1));

    // Pulse sequencer: latches config on start, steps the accumulator on each transfer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_ftw    <= '0;
            r_poff   <= '0;
            r_count  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // start has priority over a simultaneous abort here
                    if (start) begin
                        if (cfg_len != '0) begin
                            r_ftw    <= cfg_ftw;
                            r_poff   <= cfg_poff;
                            r_count  <= cfg_len;
                            r_acc    <= '0;
                            r_tdata  <= cfg_poff;
                            r_tvalid <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // a beat accepted in the abort cycle still advances state
                    if (w_hs) begin
                        r_acc   <= w_acc_next;
                        r_tdata <= w_acc_next + r_poff;
                        r_count <= r_count - LEN_W'(1);
                    end
                    if (abort) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_hs && w_last) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tvalid <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_phase.tdata  = r_tdata;
    assign m_axis_phase.tvalid = r_tvalid;
    assign busy                = r_busy;
    assign done                = r_done;
endmodule

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
- Upstream phase-word source for the DDS compiler core; drives its s_axis_phase channel (8-bit phase word) with a frequency-tuning-word accumulator plus a static phase offset.
- Generates gated qubit drive pulses: on start, emits exactly cfg_len phase beats, then signals done.
- Honours AXI-stream backpressure through m_axis_phase_tready; tie it high when the core exposes no tready.

Parameters:
- PHASE_W, 8, width of phase accumulator, tuning word, offset and output tdata.
- LEN_W, 16, width of pulse-length (beat count) configuration.

Ports:
- aclk  in  1  system clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_ftw  in  PHASE_W  frequency tuning word (phase increment per beat), unsigned.
- cfg_poff  in  PHASE_W  phase offset added to accumulator, unsigned.
- cfg_len  in  LEN_W  number of beats in pulse.
- start  in  1  single-cycle request to begin a pulse.
- abort  in  1  terminate the running pulse.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last beat transfers.
- m_axis_phase_tdata  out  PHASE_W  phase word to DDS.
- m_axis_phase_tvalid  out  1  phase word valid.
- m_axis_phase_tready  in  1  downstream ready.

Behaviour:
- Reset (aresetn=0, asynchronous assert, synchronous release): state IDLE; acc, count, tdata = 0; tvalid, busy, done = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE: tvalid=0, busy=0. start=1 and cfg_len!=0: latch ftw/poff/len, acc<=0, count<=cfg_len, tdata<=cfg_poff, go RUN. start=1 and cfg_len==0: go DONE (done pulse, no beats). start=0: stay.
- Latency: start sampled at edge N; tvalid=1 with tdata=poff from edge N (visible in cycle N+1).
- RUN: tvalid=1, busy=1. Handshake = tvalid & tready. On handshake: acc<=acc+ftw (mod 2^PHASE_W); tdata<=acc+ftw+poff (mod 2^PHASE_W); count<=count-1. Handshake with count==1: go DONE, tvalid<=0.
- Beat k (0-based) carries (k*ftw + poff) mod 2^PHASE_W; wrap-around is silent modulo arithmetic, no flag.
- Backpressure: tvalid=1 & tready=0 holds tdata, acc and count unchanged; tvalid never drops before the transfer (AXI rule).
- DONE: done=1 for exactly one cycle, tvalid=0, busy=0; next state IDLE. start in DONE is ignored.
- abort in RUN: go IDLE next edge, tvalid<=0, no done pulse. If a handshake coincides with abort, the beat counts as transferred, but no further beats follow. abort outside RUN: no effect.
- start in RUN or DONE: ignored. cfg_* changes while not IDLE: ignored (latched copies used).
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-pulse: immediate return to reset values; no done pulse.

Test Plan:
- ftw=20, poff=0, len=4, tready=1: tdata 0,20,40,60 on four consecutive valid cycles; done high one cycle on the cycle after beat 60; busy high exactly 4 cycles.
- ftw=100, poff=200, len=4, tready=1: tdata 200,44,144,244 (mod-256 wrap); done follows.
- ftw=20, poff=0, len=4, tready low for 3 cycles after beat 20 is presented: tdata held at 20 throughout, tvalid stays 1; total 4 transfers 0,20,40,60, then done.
- len=0, start: no tvalid at any cycle; done pulse one cycle after start; busy stays 0.
- ftw=1, poff=0, len=100, abort after 5 transfers: tvalid drops next edge, no done pulse; a start pulse during the run is ignored; a new start with len=2 then yields 0,1.
- aresetn asserted mid-pulse (asynchronously, between edges): tvalid, busy, done and tdata go 0 immediately; after release, state is IDLE and the next start with len=2 yields 0,ftw.
